// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store stage driving one Avalon data access; `define MEM_ALIGN_CHECK_EN to reject misaligned half/word ops
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_result,
  output logic        err
);
  localparam logic [6:0] OP_LB = 7'd42, OP_LBU = 7'd43, OP_LH = 7'd44, OP_LHU = 7'd45,
                         OP_LW = 7'd47, OP_LWL = 7'd48, OP_LWR = 7'd49,
                         OP_SB = 7'd50, OP_SH = 7'd51, OP_SW = 7'd52;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  state_t      state_q, state_d;
  logic [6:0]  op_q;
  logic [31:0] addr_q, sd_q, rt_q, load_q, load_d, cnt_q, cnt_d, ld_val;
  logic        err_q, err_d, mis_q, mis_in, valid_in;
  logic        is_ld, is_st, is_byte, is_half, active;
  logic [1:0]  k;
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  sl, sr;
  assign valid_in = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW};
`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in = ((op inside {OP_LH, OP_LHU, OP_SH}) && addr[0]) ||
                  ((op inside {OP_LW, OP_SW}) && addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif
  assign is_ld   = op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
  assign is_st   = op_q inside {OP_SB, OP_SH, OP_SW};
  assign is_byte = op_q inside {OP_LB, OP_LBU, OP_SB};
  assign is_half = op_q inside {OP_LH, OP_LHU, OP_SH};
  assign k       = addr_q[1:0];
  assign sl      = {~k, 3'b000};
  assign sr      = {k, 3'b000};
  assign active  = state_q == S_REQ && !mis_q;
  assign b       = mem_readdata[8*k +: 8];
  assign h       = k[1] ? mem_readdata[31:16] : mem_readdata[15:0];
  assign ld_val  = op_q == OP_LB  ? {{24{b[7]}}, b} :
                   op_q == OP_LBU ? {24'b0, b} :
                   op_q == OP_LH  ? {{16{h[15]}}, h} :
                   op_q == OP_LHU ? {16'b0, h} :
                   op_q == OP_LWL ? (mem_readdata << sl) | (rt_q & ~(32'hFFFF_FFFF << sl)) :
                   op_q == OP_LWR ? (mem_readdata >> sr) | (rt_q & ~(32'hFFFF_FFFF >> sr)) :
                   mem_readdata;
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_read       = active && is_ld;
  assign mem_write      = active && is_st;
  assign mem_byteenable = !active ? 4'b0000 :
                          is_byte ? 4'b0001 << k :
                          is_half ? (k[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign mem_writedata  = op_q == OP_SB ? {4{sd_q[7:0]}} :
                          op_q == OP_SH ? {2{sd_q[15:0]}} : sd_q;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
  assign err         = done && err_q;
  assign load_result = load_q;
  // Next state: accept in IDLE, hold request until the slave releases or the wait limit hits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = valid_in ? S_REQ : S_DONE;
      end
      S_REQ: if (mis_q) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else if (!mem_waitrequest) begin
        state_d = S_DONE;
        load_d  = is_ld ? ld_val : load_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
        if (WAIT_LIMIT != 0 && cnt_d == WAIT_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State, wait counter, result and request capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      rt_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
      if (state_q == S_IDLE && start) begin
        op_q   <= op;
        addr_q <= addr;
        sd_q   <= store_data;
        rt_q   <= rt_old;
        mis_q  <= mis_in;
      end
    end
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU in the multicycle MIPS core.
- Takes the ALU result as the effective address for LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW, and drives one Avalon-style data-memory transaction.
- Returns the aligned, extended or merged load value for register writeback.
- Uses the same 7-bit opcode encoding as the ALU: LB=42, LBU=43, LH=44, LHU=45, LW=47, LWL=48, LWR=49, SB=50, SH=51, SW=52.

Parameters:
WAIT_LIMIT, 255, max consecutive cycles of mem_waitrequest tolerated before abort; 0 = unlimited

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request strobe, sampled only in IDLE
op  in  7  opcode, captured with start
addr  in  32  effective byte address (base+offset), captured with start
store_data  in  32  rt value for stores, captured with start
rt_old  in  32  current rt value for LWL/LWR merge, captured with start
mem_address  out  32  word-aligned address {addr[31:2],2'b00}
mem_read  out  1  read request
mem_write  out  1  write request
mem_byteenable  out  4  active lanes; lane k = bits 8k+7:8k = byte offset k (little-endian)
mem_writedata  out  32  lane-shifted store data
mem_readdata  in  32  valid in the cycle mem_read=1 and mem_waitrequest=0
mem_waitrequest  in  1  slave stall
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
load_result  out  32  writeback value; held from done until next start
err  out  1  pulses with done on misalign or timeout

Behaviour:
- Reset: state=IDLE; all outputs 0; wait counter cleared. Applies mid-transaction: read/write drop at that edge, no done.
- States:
  - IDLE: start=1 -> REQ (start with an unlisted op -> DONE, no access, load_result unchanged).
  - REQ: mem_read or mem_write held with stable address, byteenable and writedata. Leave when mem_waitrequest=0.
    - Read: capture mem_readdata.
    - Then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: start at cycle N. Request visible N+1. With no wait states, done at N+2; each wait cycle adds 1. start during busy is ignored.
- Byte enables, with k=addr[1:0]:
  - byte ops: 1<<k
  - half ops: 4'b0011 (k=0), 4'b1100 (k=2)
  - word ops: 4'b1111
  - LWL/LWR: 4'b1111
- Store data: SB replicates byte to all lanes; SH replicates halfword to both halves; SW passes through.
- Load results, with W=mem_readdata:
  - LB/LBU: byte lane k, sign-extended / zero-extended.
  - LH/LHU: half at lane k, sign-extended / zero-extended.
  - LW: W.
  - LWL: (W << 8*(3-k)) | (rt_old & ~(32'hFFFFFFFF << 8*(3-k))).
  - LWR: (W >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)).
- Timeout: the counter increments each REQ cycle with waitrequest=1. When it reaches WAIT_LIMIT (nonzero):
  - deassert the request;
  - go to DONE with err=1;
  - leave load_result unchanged.
- Stores never change load_result.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no memory access. Go straight to DONE with err=1 (done at N+2) and leave load_result unchanged.
- Undefined: no check. Halfword ops use k&2; word ops ignore addr[1:0]. err is raised only by timeout.

Test Plan:
- LW addr=0x100, readdata=0xDEADBEEF, no wait -> mem_address=0x100, byteenable=1111, done at N+2, load_result=0xDEADBEEF.
- LB addr=0x103, readdata=0x80112233 -> byteenable=1000, load_result=0xFFFFFF80. LBU with same stimulus -> 0x00000080.
- SH addr=0x202, store_data=0x0000ABCD, 3 wait cycles -> mem_write held 4 cycles, byteenable=1100, writedata=0xABCDABCD, done at N+5.
- LWL addr=0x301, W=0x44332211, rt_old=0xAABBCCDD -> 0x2211CCDD. LWR addr=0x301, same W and rt_old -> 0xAA443322.
- WAIT_LIMIT=4, waitrequest stuck high -> request drops after 4 cycles, done=1, err=1, load_result unchanged. Reset asserted mid-REQ -> outputs 0, no done.
- With MEM_ALIGN_CHECK_EN: LW addr=0x102 -> no mem_read, done and err at N+2. Without the macro -> read at 0x100, err=0.
